// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths and the writeback request
// record used by the register file, decode and the writeback arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, search starting one
// past the last committed grant. The pointer only moves when the caller
// says the grant was a real one (advance), so throw-away grants do not
// disturb fairness.
module rr_arbiter #(
  parameter int NSRC = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NSRC-1:0]           req,
  input  logic                      enable,
  input  logic                      advance,
  output logic [NSRC-1:0]           grant,
  output logic [$clog2(NSRC)-1:0]   last_grant
);

  localparam int LG_W = $clog2(NSRC);

  logic [LG_W-1:0] cand;
  logic [LG_W-1:0] grant_idx;
  logic            found;

  // Pick the first requester after last_grant, wrapping modulo NSRC.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int off = 1; off <= NSRC; off++) begin
      cand = LG_W'((int'(last_grant) + off) % NSRC);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // Commit the pointer on a real grant; after reset source 0 is first.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      last_grant <= LG_W'(NSRC - 1);
    end else if (found && advance) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Writeback front end for the 32x32 register file: round-robin arbitration
// of execution-unit writebacks, a small write FIFO, a registered single
// write port, and combinational pending-write queries for decode.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int NSRC  = 3,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NSRC-1:0]              src_valid,
  input  logic [NSRC*REG_ADDR_W-1:0]   src_addr,
  input  logic [NSRC*REG_DATA_W-1:0]   src_data,
  output logic [NSRC-1:0]              src_ready,
  input  logic                         hold,
  output logic [REG_ADDR_W-1:0]        Waddr,
  output logic [REG_DATA_W-1:0]        Data_In,
  output logic                         W_en,
  input  logic [REG_ADDR_W-1:0]        chk_addr1,
  input  logic [REG_ADDR_W-1:0]        chk_addr2,
  output logic                         chk_hit1,
  output logic                         chk_hit2,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LG_W  = $clog2(NSRC);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, slot;
  logic [CNT_W-1:0] count;

  logic [NSRC-1:0]  grant;
  logic [LG_W-1:0]  rr_ptr_unused;
  wb_req_t          sel_req;
  logic             pop, can_accept, granted, nonzero, bypass, push_fifo;

  // Drain whenever something is queued and the port is not borrowed.
  assign pop        = (count != '0) && !hold;
  // Room now, or room made by this cycle's pop; nothing is granted in reset.
  assign can_accept = !reset && ((count < CNT_W'(DEPTH)) || pop);

  rr_arbiter #(.NSRC(NSRC)) u_arb (
    .clock      (clock),
    .reset      (reset),
    .req        (src_valid),
    .enable     (can_accept),
    .advance    (nonzero),
    .grant      (grant),
    .last_grant (rr_ptr_unused)
  );

  assign src_ready = grant;
  assign granted   = |grant;
  assign nonzero   = sel_req.addr != REG_ZERO;
  // An empty, undrained-by-hold queue lets the winner go straight to the port.
  assign bypass    = granted && nonzero && (count == '0) && !hold;
  assign push_fifo = granted && nonzero && !bypass;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));

  // Select the granted source's request from the flat input buses.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        sel_req.addr = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_req.data = src_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  // Queue storage; validity is tracked by count, so contents need no reset.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; stale slots are never read.
    if (push_fifo) begin
      mem[wr_ptr] <= sel_req;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)       rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_fifo) - CNT_W'(pop);
    end
  end

  // Registered write port: head entry first, else the bypassed request.
  always_ff @(posedge clock) begin
    if (reset) begin
      W_en    <= 1'b0;
      Waddr   <= '0;
      Data_In <= '0;
    end else if (pop) begin
      W_en    <= 1'b1;
      Waddr   <= mem[rd_ptr].addr;
      Data_In <= mem[rd_ptr].data;
    end else if (bypass) begin
      W_en    <= 1'b1;
      Waddr   <= sel_req.addr;
      Data_In <= sel_req.data;
    end else begin
      W_en    <= 1'b0;
    end
  end

  // Pending-write lookup over queued entries plus the write on the port now.
  always_comb begin
    slot     = '0;
    chk_hit1 = W_en && (Waddr == chk_addr1);
    chk_hit2 = W_en && (Waddr == chk_addr2);
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if (mem[slot].addr == chk_addr1) chk_hit1 = 1'b1;
        if (mem[slot].addr == chk_addr2) chk_hit2 = 1'b1;
      end
    end
    chk_hit1 = chk_hit1 && (chk_addr1 != REG_ZERO);
    chk_hit2 = chk_hit2 && (chk_addr2 != REG_ZERO);
  end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb with hand-computed expectations.
module tb_regfile_wb_arb;
  import regfile_pkg::*;

  localparam int NSRC  = 3;
  localparam int DEPTH = 4;

  logic                        clock;
  logic                        reset;
  logic [NSRC-1:0]             src_valid;
  logic [NSRC*REG_ADDR_W-1:0]  src_addr;
  logic [NSRC*REG_DATA_W-1:0]  src_data;
  logic [NSRC-1:0]             src_ready;
  logic                        hold;
  logic [REG_ADDR_W-1:0]       Waddr;
  logic [REG_DATA_W-1:0]       Data_In;
  logic                        W_en;
  logic [REG_ADDR_W-1:0]       chk_addr1, chk_addr2;
  logic                        chk_hit1, chk_hit2;
  logic                        empty, full;

  int n_cmp = 0;
  int n_err = 0;
  int na;

  regfile_wb_arb #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .src_valid (src_valid),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .src_ready (src_ready),
    .hold      (hold),
    .Waddr     (Waddr),
    .Data_In   (Data_In),
    .W_en      (W_en),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_hit1  (chk_hit1),
    .chk_hit2  (chk_hit2),
    .empty     (empty),
    .full      (full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
    src_addr[i*REG_ADDR_W +: REG_ADDR_W] = a;
    src_data[i*REG_DATA_W +: REG_DATA_W] = d;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; src_valid = '0; src_addr = '0; src_data = '0;
    chk_addr1 = 5'd5; chk_addr2 = 5'd0;

    // Reset state.
    tick(); tick();
    check("rst_ready", src_ready, 0);
    check("rst_wen",   W_en, 0);
    check("rst_waddr", Waddr, 0);
    check("rst_data",  Data_In, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full, 0);
    check("rst_hit1",  chk_hit1, 0);
    check("rst_lg",    dut.u_arb.last_grant, 2);
    reset = 1'b0;

    // Round-robin across three continuous requesters.
    set_src(0, 5'd1, 32'hA1); set_src(1, 5'd2, 32'hA2); set_src(2, 5'd3, 32'hA3);
    src_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_ready", src_ready, 64'(1 << (c % 3)));
      check("rr_wen", W_en, (c > 0));
      if (c > 0) check("rr_waddr", Waddr, ((c - 1) % 3) + 1);
      if (c == 1) check("rr_data", Data_In, 32'hA1);
      tick();
    end
    src_valid = '0;
    #1;
    check("rr_last_wen",   W_en, 1);
    check("rr_last_waddr", Waddr, 3);
    check("rr_last_data",  Data_In, 32'hA3);
    check("rr_lg",         dut.u_arb.last_grant, 2);
    tick();

    // Single request, FIFO empty: one-cycle latency, queue never occupied.
    set_src(1, 5'd5, 32'hDEADBEEF);
    src_valid = 3'b010;
    #1;
    check("single_ready", src_ready, 3'b010);
    tick();
    src_valid = '0;
    #1;
    check("single_wen",   W_en, 1);
    check("single_waddr", Waddr, 5);
    check("single_data",  Data_In, 32'hDEADBEEF);
    check("single_empty", empty, 1);
    check("single_lg",    dut.u_arb.last_grant, 1);
    tick();
    check("idle_wen",        W_en, 0);
    check("idle_waddr_hold", Waddr, 5);
    check("idle_data_hold",  Data_In, 32'hDEADBEEF);

    // Zero register: handshake completes, no write, pointer unchanged.
    set_src(0, 5'd0, 32'h1234);
    src_valid = 3'b001;
    #1;
    check("zero_ready", src_ready, 3'b001);
    tick();
    src_valid = '0;
    #1;
    check("zero_lg",    dut.u_arb.last_grant, 1);
    check("zero_wen",   W_en, 0);
    check("zero_empty", empty, 1);
    tick();
    check("zero_wen2", W_en, 0);

    // Zero-address winner blocks a lower-priority requester for that cycle.
    set_src(1, 5'd6, 32'h66);
    src_valid = 3'b011;
    #1;
    check("zprio_ready0", src_ready, 3'b001);
    tick();
    src_valid = 3'b010;
    #1;
    check("zprio_ready1", src_ready, 3'b010);
    check("zprio_wen0",   W_en, 0);
    tick();
    src_valid = '0;
    #1;
    check("zprio_wen1",  W_en, 1);
    check("zprio_waddr", Waddr, 6);
    check("zprio_lg",    dut.u_arb.last_grant, 1);
    tick();

    // Hold with a streaming source: exactly DEPTH accepted, then stalled.
    hold = 1'b1;
    src_valid = 3'b100;
    na = 8;
    for (int c = 0; c < 6; c++) begin
      set_src(2, 5'(na), 32'h100 + 32'(na));
      #1;
      check("hold_ready", src_ready, (c < 4) ? 3'b100 : 3'b000);
      check("hold_wen", W_en, 0);
      if (src_ready[2]) na++;
      tick();
    end
    check("hold_full",  full, 1);
    check("hold_empty", empty, 0);

    // Release hold: pop and push in the same cycle while full.
    hold = 1'b0;
    set_src(2, 5'(na), 32'h100 + 32'(na));
    #1;
    check("rel_ready", src_ready, 3'b100);
    tick();
    src_valid = '0;
    #1;
    check("rel_data8", Data_In, 32'h108);
    for (int k = 0; k < 5; k++) begin
      check("rel_wen",   W_en, 1);
      check("rel_waddr", Waddr, 8 + k);
      tick();
    end
    check("rel_done_wen",   W_en, 0);
    check("rel_done_empty", empty, 1);

    // Pending-write query.
    hold = 1'b1;
    set_src(0, 5'd7, 32'h77);
    src_valid = 3'b001;
    #1;
    check("pend_ready", src_ready, 3'b001);
    tick();
    src_valid = '0;
    chk_addr1 = 5'd7; chk_addr2 = 5'd0;
    #1;
    check("pend_hit1",  chk_hit1, 1);
    check("pend_hit2z", chk_hit2, 0);
    check("pend_empty", empty, 0);
    chk_addr2 = 5'd9;
    #1;
    check("pend_hit2_miss", chk_hit2, 0);
    hold = 1'b0;
    #1;
    check("pend_hit1_rel", chk_hit1, 1);
    tick();
    check("pend_wen",        W_en, 1);
    check("pend_waddr",      Waddr, 7);
    check("pend_hit1_fly",   chk_hit1, 1);
    tick();
    check("pend_wen_off",    W_en, 0);
    check("pend_hit1_clear", chk_hit1, 0);

    // Reset with three writes queued.
    hold = 1'b1;
    src_valid = 3'b010;
    for (int a = 20; a < 23; a++) begin
      set_src(1, 5'(a), 32'(a));
      #1;
      check("mid_ready", src_ready, 3'b010);
      tick();
    end
    chk_addr1 = 5'd21;
    #1;
    check("mid_hit_before", chk_hit1, 1);
    reset = 1'b1;
    hold = 1'b0;
    set_src(1, 5'd23, 32'd23);
    #1;
    check("mid_ready_in_reset", src_ready, 0);
    tick();
    reset = 1'b0;
    src_valid = '0;
    #1;
    check("mid_empty", empty, 1);
    check("mid_full",  full, 0);
    check("mid_wen",   W_en, 0);
    check("mid_hit",   chk_hit1, 0);
    check("mid_lg",    dut.u_arb.last_grant, 2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_stale_wen", W_en, 0);
      check("mid_no_stale_empty", empty, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
